// File: rtl/dunit_if_ctrl.sv
// Debug-unit instruction-fetch controller: decodes UART command bytes, assembles and writes
// program words into instruction memory, and gates the pipeline clock for run/step.
module dunit_if_ctrl #(
  parameter int unsigned NB_REG   = 32,
  parameter int unsigned NB_WIDHT = 9
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic [7:0]          i_rx_data,
  input  logic                i_rx_valid,
  input  logic                i_halt,
  output logic                o_dunit_w_en,
  output logic [NB_WIDHT-1:0] o_dunit_addr,
  output logic [NB_REG-1:0]   o_dunit_data,
  output logic                o_dunit_clk_en,
  output logic                o_load_done,
  output logic [2:0]          o_state
);

  localparam logic [7:0] CmdLoad = 8'h4C;
  localparam logic [7:0] CmdRun  = 8'h52;
  localparam logic [7:0] CmdStep = 8'h53;
  localparam logic [7:0] CmdHalt = 8'h48;

  localparam logic [NB_REG-1:0]   HaltWord = {NB_REG{1'b1}};
  // Last word-aligned address in the memory; writing it ends the load.
  localparam logic [NB_WIDHT-1:0] LastAddr = {{(NB_WIDHT-2){1'b1}}, 2'b00};
  localparam logic [NB_WIDHT-1:0] AddrStep = NB_WIDHT'(4);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoad  = 3'd1,
    StWrite = 3'd2,
    StRun   = 3'd3,
    StStep  = 3'd4
  } state_t;

  state_t              r_state;
  logic                r_w_en;
  logic                r_clk_en;
  logic                r_load_done;
  logic [NB_WIDHT-1:0] r_addr;
  logic [NB_REG-1:0]   r_data;
  logic [1:0]          r_byte_cnt;

  logic w_byte_ok;
  logic w_last_word;

  assign w_byte_ok   = i_rx_valid;
  assign w_last_word = (r_data == HaltWord) || (r_addr == LastAddr);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= StIdle;
      r_w_en      <= 1'b0;
      r_clk_en    <= 1'b0;
      r_load_done <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_byte_cnt  <= '0;
    end else begin
      r_w_en      <= 1'b0;
      r_clk_en    <= 1'b0;
      r_load_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_byte_ok) begin
            if (i_rx_data == CmdLoad) begin
              r_state    <= StLoad;
              r_addr     <= '0;
              r_byte_cnt <= '0;
            end else if (i_rx_data == CmdRun) begin
              r_state  <= StRun;
              r_clk_en <= 1'b1;
            end else if (i_rx_data == CmdStep) begin
              r_state  <= StStep;
              r_clk_en <= 1'b1;
            end
          end
        end
        StLoad: begin
          if (w_byte_ok) begin
            // MSB-first: the first byte of a word ends up in the top byte.
            r_data     <= {r_data[NB_REG-9:0], i_rx_data};
            r_byte_cnt <= r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              r_state <= StWrite;
              r_w_en  <= 1'b1;
            end
          end
        end
        StWrite: begin
          r_addr     <= r_addr + AddrStep;
          r_byte_cnt <= '0;
          if (w_last_word) begin
            r_state     <= StIdle;
            r_load_done <= 1'b1;
          end else begin
            r_state <= StLoad;
          end
        end
        StRun: begin
          if (i_halt || (w_byte_ok && (i_rx_data == CmdHalt))) begin
            r_state <= StIdle;
          end else begin
            r_clk_en <= 1'b1;
          end
        end
        StStep: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_dunit_w_en   = r_w_en;
  assign o_dunit_addr   = r_addr;
  assign o_dunit_data   = r_data;
  assign o_dunit_clk_en = r_clk_en;
  assign o_load_done    = r_load_done;
  assign o_state        = r_state;

endmodule

// File: doc/dunit_if_ctrl.md
DUNIT_IF_CTRL -- requirements
Module: dunit_if_ctrl

Interface
REQ-001 SHALL have parameter NB_REG, default 32: width of instruction word written to instruction memory.
REQ-002 SHALL have parameter NB_WIDHT, default 9: instruction-memory byte-address width (512 bytes).
REQ-003 SHALL have port i_clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port i_reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port i_rx_data  input  8  command/program byte from UART receiver.
REQ-006 SHALL have port i_rx_valid  input  1  one-cycle strobe qualifying i_rx_data.
REQ-007 SHALL have port i_halt  input  1  pipeline has reached HALT, level.
REQ-008 SHALL have port o_dunit_w_en  output  1  instruction-memory write strobe.
REQ-009 SHALL have port o_dunit_addr  output  NB_WIDHT  instruction-memory byte address.
REQ-010 SHALL have port o_dunit_data  output  NB_REG  assembled instruction word.
REQ-011 SHALL have port o_dunit_clk_en  output  1  pipeline/PC advance enable.
REQ-012 SHALL have port o_load_done  output  1  one-cycle pulse when program load ends.
REQ-013 SHALL have port o_state  output  3  encoded FSM state.

Function
REQ-014 SHALL implement states IDLE=0, LOAD=1, WRITE=2, RUN=3, STEP=4; o_state = current state.
REQ-015 IDLE: byte 0x4C ('L') -> LOAD with address counter and byte counter cleared; 0x52 ('R') -> RUN; 0x53 ('S') -> STEP; other bytes ignored.
REQ-016 LOAD: each i_rx_valid byte shifts into word register MSB-first (first byte lands in [31:24]); byte counter 0..3.
REQ-017 On 4th byte accepted, SHALL enter WRITE next cycle; WRITE lasts exactly one cycle with o_dunit_w_en=1, o_dunit_addr = word address, o_dunit_data = assembled word.
REQ-018 After WRITE, address SHALL increment by 4 (mod 2^NB_WIDHT), byte counter cleared.
REQ-019 Leaving WRITE: word 0xFFFFFFFF (HALT) or address just written = 2^NB_WIDHT-4 -> IDLE with o_load_done pulse in that same transition cycle; else -> LOAD.
REQ-020 i_rx_valid during WRITE SHALL be ignored (byte lost; transmitter guarantees ≥2-cycle spacing).
REQ-021 RUN: o_dunit_clk_en=1 every cycle; i_halt=1 or byte 0x48 ('H') -> IDLE, o_dunit_clk_en=0 from the next cycle.
REQ-022 STEP: o_dunit_clk_en=1 for exactly one cycle, then IDLE unconditionally.
REQ-023 Outside RUN/STEP, o_dunit_clk_en SHALL be 0; outside WRITE, o_dunit_w_en SHALL be 0.
REQ-024 All outputs SHALL be registered; command byte to first clk_en cycle latency = 1 cycle.
REQ-025 i_halt SHALL be ignored in IDLE/LOAD/WRITE and in STEP.
REQ-026 'L','R','S' received outside IDLE SHALL be treated as data (LOAD) or ignored (RUN/STEP).

Reset
REQ-027 i_reset asserted SHALL immediately force IDLE, o_dunit_w_en=0, o_dunit_clk_en=0, o_load_done=0, o_dunit_addr=0, o_dunit_data=0, o_state=0, counters=0, regardless of state (mid-load partial word discarded).
REQ-028 After reset release, first accepted byte SHALL be interpreted as a command.

Verification
REQ-029 'L' then 00 00 00 20, FF FF FF FF -> WRITE addr 0 data 0x00000020, WRITE addr 4 data 0xFFFFFFFF, o_load_done pulse, state IDLE.
REQ-030 'L' then 127 non-HALT words -> addresses 0..504 written; 128th word written at 508 -> load_done, IDLE, address wraps to 0.
REQ-031 'R', hold i_halt=0 for 10 cycles, then i_halt=1 -> clk_en high 10+ cycles, low one cycle after halt sampled, state IDLE.
REQ-032 'S' three times (spaced) -> exactly three single-cycle clk_en pulses, state returns to IDLE after each.
REQ-033 'L', 2 bytes, assert i_reset -> all outputs 0 immediately; next 'L' + 4 bytes writes address 0 with only the new bytes.
REQ-034 'R' then 'H' byte with i_halt=0 -> RUN exits to IDLE, clk_en deasserted next cycle; 'H' in IDLE ignored.
